// File: rtl/cmp_lut_pipe.sv
// Compares streamed A against constant B_CONST with per-chunk LUT compares merged in a registered tree.
// Latency clog2(NCHUNK)+2; every stage freezes while OUT_VALID waits on OUT_READY.
module cmp_lut_pipe #(
  parameter int               WIDTH     = 16,
  parameter int               LUT_WIDTH = 4,
  parameter int               SIGNED    = 0,
  parameter logic [WIDTH-1:0] B_CONST   = '0
) (
  input  logic             CLK,
  input  logic             SRST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             Y,
  output logic             ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int NCHUNK = (WIDTH + LUT_WIDTH - 1) / LUT_WIDTH;
  localparam int LEVELS = (NCHUNK > 1) ? $clog2(NCHUNK) : 0;
  localparam int EXT    = NCHUNK * LUT_WIDTH;

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_GT = 3'd2;
  localparam logic [2:0] OP_GE = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  // Flipping the extended sign bit maps two's-complement order onto unsigned order.
  function automatic logic [EXT-1:0] extend(input logic [WIDTH-1:0] v);
    logic [EXT-1:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    if (SIGNED != 0) begin
      for (int k = WIDTH; k < EXT; k++) r[k] = v[WIDTH-1];
      r[EXT-1] = ~r[EXT-1];
    end
    return r;
  endfunction

  function automatic int nodes_at(input int lvl);
    int n;
    n = NCHUNK;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  localparam logic [EXT-1:0] B_EXT = extend(B_CONST);

  logic [EXT-1:0]    a_ext;
  logic [NCHUNK-1:0] lt_d [LEVELS+1];
  logic [NCHUNK-1:0] eq_d [LEVELS+1];
  logic [NCHUNK-1:0] lt_q [LEVELS+1];
  logic [NCHUNK-1:0] eq_q [LEVELS+1];
  logic [2:0]        op_q [LEVELS+1];
  logic [LEVELS:0]   vld_q;
  logic              out_vld_q;
  logic              y_q;
  logic              err_q;
  logic              stall;
  logic              root_lt;
  logic              root_eq;
  logic              y_dec;
  logic              err_dec;

  assign a_ext    = extend(A);
  assign stall    = out_vld_q & ~OUT_READY;
  assign IN_READY = ~stall;

  // Level 0 is the per-chunk compare; level l merges (hi, lo) pairs of level l-1.
  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      lt_d[l] = '0;
      eq_d[l] = '0;
    end
    for (int i = 0; i < NCHUNK; i++) begin
      lt_d[0][i] = a_ext[i*LUT_WIDTH +: LUT_WIDTH] <  B_EXT[i*LUT_WIDTH +: LUT_WIDTH];
      eq_d[0][i] = a_ext[i*LUT_WIDTH +: LUT_WIDTH] == B_EXT[i*LUT_WIDTH +: LUT_WIDTH];
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < NCHUNK; j++) begin
        if (j < nodes_at(l)) begin
          if (2*j + 1 < nodes_at(l - 1)) begin
            lt_d[l][j] = lt_q[l-1][2*j+1] | (eq_q[l-1][2*j+1] & lt_q[l-1][2*j]);
            eq_d[l][j] = eq_q[l-1][2*j+1] & eq_q[l-1][2*j];
          end else begin
            lt_d[l][j] = lt_q[l-1][2*j];
            eq_d[l][j] = eq_q[l-1][2*j];
          end
        end
      end
    end
  end

  always_comb begin
    root_lt = lt_q[LEVELS][0];
    root_eq = eq_q[LEVELS][0];
    y_dec   = 1'b0;
    err_dec = 1'b0;
    case (op_q[LEVELS])
      OP_LT:   y_dec = root_lt;
      OP_LE:   y_dec = root_lt | root_eq;
      OP_GT:   y_dec = ~root_lt & ~root_eq;
      OP_GE:   y_dec = ~root_lt;
      OP_EQ:   y_dec = root_eq;
      OP_NE:   y_dec = ~root_eq;
      default: err_dec = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
      y_q       <= 1'b0;
      err_q     <= 1'b0;
      for (int l = 0; l <= LEVELS; l++) begin
        lt_q[l] <= '0;
        eq_q[l] <= '0;
        op_q[l] <= '0;
      end
    end else if (!stall) begin
      vld_q[0] <= IN_VALID;
      op_q[0]  <= OP;
      for (int l = 0; l <= LEVELS; l++) begin
        lt_q[l] <= lt_d[l];
        eq_q[l] <= eq_d[l];
      end
      for (int l = 1; l <= LEVELS; l++) begin
        vld_q[l] <= vld_q[l-1];
        op_q[l]  <= op_q[l-1];
      end
      // Bubbles load zeros so Y/ERR read 0 whenever nothing is presented.
      out_vld_q <= vld_q[LEVELS];
      y_q       <= vld_q[LEVELS] & y_dec;
      err_q     <= vld_q[LEVELS] & err_dec;
    end
  end

  assign Y         = y_q;
  assign ERR       = err_q;
  assign OUT_VALID = out_vld_q;

endmodule
